// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
//  Module   : lc3b_types (package)
//  Brief    : Shared LC-3b cache types: CPU word, cache line, line offset and
//             line tag, plus the fixed datapath widths.
//  Revision : 1.0 - initial release
// ============================================================================
package lc3b_types;

    localparam int LINE_W = 128;   // cache line width in bits
    localparam int WORD_W = 16;    // CPU word width in bits

    typedef logic [WORD_W-1:0] lc3b_word;
    typedef logic [LINE_W-1:0] lc3b_c_line;
    typedef logic [3:0]        lc3b_c_offset;
    typedef logic [11:0]       lc3b_c_tag;
    typedef logic [1:0]        lc3b_mem_be;

endpackage : lc3b_types
`default_nettype wire

// File: rtl/line_word_mux.sv
`default_nettype none
// ============================================================================
//  Module   : line_word_mux
//  Brief    : Combinational word extract from a 128-bit cache line followed by
//             byte right-alignment. offset[0] is ignored (word aligned select).
//             byte_enable: 01 low byte, 10 high byte, 11/00 full word.
//  Revision : 1.0 - initial release
// ============================================================================
module line_word_mux
    import lc3b_types::*;
(
    input  logic [LINE_W-1:0] i_line,
    input  logic [3:0]        i_offset,
    input  logic [1:0]        i_byte_enable,
    output logic [WORD_W-1:0] o_data
);

    lc3b_word w_word;
    logic     w_unused_offset_lsb;

    // The byte address LSB never selects a lane; bytes are picked by byte_enable.
    assign w_unused_offset_lsb = i_offset[0];

    // Pick the 16-bit lane, then right-align the requested byte.
    always_comb begin
        w_word = i_line[WORD_W*i_offset[3:1] +: WORD_W];
        case (i_byte_enable)
            2'b10:   o_data = {8'h00, w_word[15:8]};
            2'b01:   o_data = {8'h00, w_word[7:0]};
            default: o_data = w_word;
        endcase
    end

endmodule : line_word_mux
`default_nettype wire

// File: rtl/line_rd_sel.sv
`default_nettype none
// ============================================================================
//  Module   : line_rd_sel
//  Brief    : Cache read-side line selector. Holds one fetched 128-bit line,
//             serves CPU word/byte reads from it on a hit (1-cycle latency)
//             or fetches the line from the data array on a miss, and returns
//             the right-aligned data with a one-cycle mem_resp pulse.
//             Optional macro LINE_RD_STATS_EN adds saturating hit/miss
//             counters (hit_count, miss_count).
//  Revision : 1.0 - initial release
// ============================================================================
module line_rd_sel
    import lc3b_types::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_read,
    input  logic [WORD_W-1:0] cpu_address,
    input  logic [1:0]        mem_byte_enable,
    output logic [WORD_W-1:0] mem_rdata,
    output logic              mem_resp,
    output logic              line_req,
    output logic [WORD_W-1:0] line_addr,
    input  logic [LINE_W-1:0] line_rdata,
    input  logic              line_resp,
`ifdef LINE_RD_STATS_EN
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count,
`endif
    input  logic              line_inv
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_RESP  = 2'd2;

    logic [1:0]   r_state,     w_state_d;
    logic         r_buf_valid, w_buf_valid_d;
    lc3b_c_tag    r_buf_tag,   w_buf_tag_d;
    lc3b_c_line   r_buf_line,  w_buf_line_d;
    lc3b_word     r_line_addr, w_line_addr_d;
    lc3b_word     r_mem_rdata, w_mem_rdata_d;
    lc3b_c_offset r_offset,    w_offset_d;
    lc3b_mem_be   r_be,        w_be_d;

    logic         w_hit;
    lc3b_c_line   w_sel_line;
    lc3b_c_offset w_sel_offset;
    lc3b_mem_be   w_sel_be;
    lc3b_word     w_sel_data;

`ifdef LINE_RD_STATS_EN
    logic [15:0]  r_hit_count,  w_hit_count_d;
    logic [15:0]  r_miss_count, w_miss_count_d;
`endif

    // An invalidate in the request cycle wins over a tag match.
    assign w_hit = r_buf_valid && (cpu_address[15:4] == r_buf_tag) && !line_inv;

    // In IDLE the select works on the live request against the buffer; in
    // FETCH it works on the captured request against the line arriving now,
    // so mem_rdata is ready on entry to RESP in both paths.
    always_comb begin
        w_sel_line   = (r_state == c_FETCH) ? line_rdata : r_buf_line;
        w_sel_offset = (r_state == c_IDLE)  ? cpu_address[3:0] : r_offset;
        w_sel_be     = (r_state == c_IDLE)  ? mem_byte_enable  : r_be;
    end

    line_word_mux u_word_mux (
        .i_line        (w_sel_line),
        .i_offset      (w_sel_offset),
        .i_byte_enable (w_sel_be),
        .o_data        (w_sel_data)
    );

    // Next-state and next-register computation for the IDLE/FETCH/RESP flow.
    always_comb begin
        w_state_d     = r_state;
        w_buf_valid_d = r_buf_valid;
        w_buf_tag_d   = r_buf_tag;
        w_buf_line_d  = r_buf_line;
        w_line_addr_d = r_line_addr;
        w_mem_rdata_d = r_mem_rdata;
        w_offset_d    = r_offset;
        w_be_d        = r_be;
`ifdef LINE_RD_STATS_EN
        w_hit_count_d  = r_hit_count;
        w_miss_count_d = r_miss_count;
`endif
        case (r_state)
            c_IDLE: begin
                if (cpu_read) begin
                    w_offset_d = cpu_address[3:0];
                    w_be_d     = mem_byte_enable;
                    if (w_hit) begin
                        w_state_d     = c_RESP;
                        w_mem_rdata_d = w_sel_data;
`ifdef LINE_RD_STATS_EN
                        if (r_hit_count != 16'hFFFF) w_hit_count_d = r_hit_count + 16'd1;
`endif
                    end else begin
                        w_state_d     = c_FETCH;
                        w_line_addr_d = {cpu_address[15:4], 4'b0000};
`ifdef LINE_RD_STATS_EN
                        if (r_miss_count != 16'hFFFF) w_miss_count_d = r_miss_count + 16'd1;
`endif
                    end
                end
            end
            c_FETCH: begin
                if (line_resp) begin
                    w_buf_line_d  = line_rdata;
                    w_buf_tag_d   = r_line_addr[15:4];
                    w_buf_valid_d = 1'b1;
                    w_mem_rdata_d = w_sel_data;
                    w_state_d     = c_RESP;
                end
            end
            c_RESP: begin
                w_state_d = c_IDLE;
            end
            default: begin
                w_state_d = c_IDLE;
            end
        endcase
        // Invalidate drops validity last so it also overrides a same-cycle fill.
        if (line_inv) begin
            w_buf_valid_d = 1'b0;
        end
    end

    // State and datapath registers; reset abandons any fetch in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_buf_valid <= 1'b0;
            r_buf_tag   <= '0;
            r_buf_line  <= '0;
            r_line_addr <= '0;
            r_mem_rdata <= '0;
            r_offset    <= '0;
            r_be        <= '0;
`ifdef LINE_RD_STATS_EN
            r_hit_count  <= '0;
            r_miss_count <= '0;
`endif
        end else begin
            r_state     <= w_state_d;
            r_buf_valid <= w_buf_valid_d;
            r_buf_tag   <= w_buf_tag_d;
            r_buf_line  <= w_buf_line_d;
            r_line_addr <= w_line_addr_d;
            r_mem_rdata <= w_mem_rdata_d;
            r_offset    <= w_offset_d;
            r_be        <= w_be_d;
`ifdef LINE_RD_STATS_EN
            r_hit_count  <= w_hit_count_d;
            r_miss_count <= w_miss_count_d;
`endif
        end
    end

    assign line_req  = (r_state == c_FETCH);
    assign mem_resp  = (r_state == c_RESP);
    assign line_addr = r_line_addr;
    assign mem_rdata = r_mem_rdata;
`ifdef LINE_RD_STATS_EN
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule : line_rd_sel
`default_nettype wire
